// File: rtl/imem_if.sv
// Fetch request/response and program-load signals shared by the instruction
// memory responder and whatever drives it.
interface imem_if #(
    parameter int AW = 11
) ();
    logic          req_valid;
    logic          req_ready;
    logic [63:0]   req_pc;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [79:0]   rsp_inst;
    logic          rsp_imem_er;
    logic          ld_en;
    logic [AW-1:0] ld_addr;
    logic [7:0]    ld_data;
    logic          ld_ready;

    modport slave (
        input  req_valid, req_pc, rsp_ready, ld_en, ld_addr, ld_data,
        output req_ready, rsp_valid, rsp_inst, rsp_imem_er, ld_ready
    );

    modport master (
        output req_valid, req_pc, rsp_ready, ld_en, ld_addr, ld_data,
        input  req_ready, rsp_valid, rsp_inst, rsp_imem_er, ld_ready
    );
endinterface

// File: rtl/imem_responder.sv
// Y86-64 instruction memory: byte-loadable storage that answers a fetch with a
// 10-byte instruction window, read two bytes per cycle over five READ beats.
module imem_responder #(
    parameter int DEPTH  = 2048,
    parameter int AW     = 11,
    parameter int IBYTES = 10
) (
    input  logic  clk,
    input  logic  rst_n,
    imem_if.slave bus,
    output logic  busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Highest start address whose full window still fits inside storage.
    localparam logic [63:0] LP_LIMIT = 64'(DEPTH - IBYTES);

    logic [7:0]    mem [DEPTH];
    state_t        r_state;
    logic [2:0]    r_beat;
    logic [AW-1:0] r_pc;
    logic [79:0]   r_inst;
    logic          r_er;
    logic          r_valid;
    logic          r_busy;
    logic          r_idle;

    logic          w_req_ready;
    logic [AW-1:0] w_addr_lo;
    logic [AW-1:0] w_addr_hi;
    logic [15:0]   w_pair;

    assign w_req_ready = r_idle && !bus.ld_en;
    assign w_addr_lo   = r_pc + AW'({r_beat, 1'b0});
    assign w_addr_hi   = w_addr_lo + AW'(1);
    assign w_pair      = {mem[w_addr_hi], mem[w_addr_lo]};

    assign bus.req_ready   = w_req_ready;
    assign bus.ld_ready    = r_idle;
    assign bus.rsp_valid   = r_valid;
    assign bus.rsp_inst    = r_inst;
    assign bus.rsp_imem_er = r_er;
    assign busy            = r_busy;

    // Program load port; storage has no reset so a loaded program survives rst_n.
    always_ff @(posedge clk) begin
        if (bus.ld_en && r_idle) begin
            mem[bus.ld_addr] <= bus.ld_data;
        end
    end

    // Fetch FSM with status flags registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_beat  <= 3'd0;
            r_pc    <= '0;
            r_inst  <= 80'd0;
            r_er    <= 1'b0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_idle  <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.req_valid && w_req_ready) begin
                        r_pc   <= bus.req_pc[AW-1:0];
                        r_busy <= 1'b1;
                        r_idle <= 1'b0;
                        if (bus.req_pc > LP_LIMIT) begin
                            r_state <= ST_RESP;
                            r_inst  <= 80'd0;
                            r_er    <= 1'b1;
                            r_valid <= 1'b1;
                        end else begin
                            r_state <= ST_READ;
                            r_beat  <= 3'd0;
                            r_er    <= 1'b0;
                        end
                    end
                end
                ST_READ: begin
                    r_inst[{r_beat, 4'b0000} +: 16] <= w_pair;
                    r_beat <= r_beat + 3'd1;
                    if (r_beat == 3'd4) begin
                        r_state <= ST_RESP;
                        r_valid <= 1'b1;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        r_state <= ST_IDLE;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                        r_idle  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_idle  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench for imem_responder: a byte-array model predicts every
// response at accept time; a monitor pops and compares on each handshake.
module tb_imem_responder;

    localparam int DEPTH = 2048;
    localparam int AW    = 11;

    typedef struct {
        logic [79:0] inst;
        logic        er;
    } exp_t;

    logic clk;
    logic rst_n;
    logic busy;

    imem_if #(.AW(AW)) bus ();

    imem_responder #(.DEPTH(DEPTH), .AW(AW), .IBYTES(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] mem_m [DEPTH];
    exp_t       exp_q [$];
    int         n_cmp = 0;
    int         n_bad = 0;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    // Reference: window of the next ten bytes, or an error for any start past DEPTH-10.
    function automatic exp_t ref_rsp(input logic [63:0] pc);
        exp_t e;
        e.inst = 80'd0;
        e.er   = 1'b0;
        if (pc > 64'(DEPTH - 10)) begin
            e.er = 1'b1;
        end else begin
            for (int k = 0; k < 10; k++) begin
                e.inst[8*k +: 8] = mem_m[int'(pc) + k];
            end
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_rsp: got a response, want none");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("rsp_inst", bus.rsp_inst, e.inst);
                check("rsp_imem_er", 80'(bus.rsp_imem_er), 80'(e.er));
            end
        end
    end

    // Called at posedge+1 while the DUT is idle.
    task automatic load_byte(input logic [AW-1:0] a, input logic [7:0] d);
        bus.ld_en   = 1'b1;
        bus.ld_addr = a;
        bus.ld_data = d;
        @(posedge clk);
        #1;
        bus.ld_en = 1'b0;
        mem_m[a]  = d;
    endtask

    // Issue one fetch, hold the response for 'hold' cycles, then consume it.
    task automatic do_req(input logic [63:0] pc, input int hold, input bit ld_mid);
        exp_t e;
        int   t;
        int   lat;
        bus.req_valid = 1'b1;
        bus.req_pc    = pc;
        t = 0;
        @(negedge clk);
        while (!bus.req_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!bus.req_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: got req_ready=0, want 1 within 20 cycles");
            bus.req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        e = ref_rsp(pc);
        exp_q.push_back(e);
        #1;
        bus.req_valid = 1'b0;
        if (ld_mid) begin
            bus.ld_en   = 1'b1;
            bus.ld_addr = AW'(4);
            bus.ld_data = 8'hEE;
        end
        // lat counts rising edges after the accept edge until rsp_valid is seen.
        lat = 0;
        @(negedge clk);
        while (!bus.rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        bus.ld_en = 1'b0;
        check("latency", 80'(lat), (pc > 64'(DEPTH - 10)) ? 80'd0 : 80'd5);
        if (!bus.rsp_valid) begin
            void'(exp_q.pop_back());
            return;
        end
        @(posedge clk);
        #1;
        repeat (hold) begin
            check("hold_valid", 80'(bus.rsp_valid), 80'd1);
            check("hold_inst", bus.rsp_inst, e.inst);
            @(posedge clk);
            #1;
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        check("idle_busy", 80'(busy), 80'd0);
        check("idle_valid", 80'(bus.rsp_valid), 80'd0);
        check("idle_inst_kept", bus.rsp_inst, e.inst);
    endtask

    initial begin
        logic [63:0] pc;
        int          sel;
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_pc    = 64'd0;
        bus.rsp_ready = 1'b0;
        bus.ld_en     = 1'b0;
        bus.ld_addr   = '0;
        bus.ld_data   = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 80'(busy), 80'd0);
        check("rst_valid", 80'(bus.rsp_valid), 80'd0);
        check("rst_inst", bus.rsp_inst, 80'd0);
        check("rst_er", 80'(bus.rsp_imem_er), 80'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_ld_ready", 80'(bus.ld_ready), 80'd1);
        check("idle_req_ready", 80'(bus.req_ready), 80'd1);

        for (int a = 0; a < DEPTH; a++) load_byte(AW'(a), 8'($urandom));

        // Reference program: irmovq-style bytes at address 0.
        load_byte(AW'(0), 8'h30);
        load_byte(AW'(1), 8'hF2);
        load_byte(AW'(2), 8'h0A);
        for (int a = 3; a < 10; a++) load_byte(AW'(a), 8'h00);
        do_req(64'd0, 0, 1'b0);
        check("prog_window", ref_rsp(64'd0).inst, 80'h0000000000000AF230);

        do_req(64'd2039, 0, 1'b0);
        do_req(64'd2038, 7, 1'b0);

        // Load and request together: the load wins, request accepted next cycle.
        bus.ld_en     = 1'b1;
        bus.ld_addr   = AW'(100);
        bus.ld_data   = 8'h5A;
        bus.req_valid = 1'b1;
        bus.req_pc    = 64'd96;
        #2;
        check("collide_req_ready", 80'(bus.req_ready), 80'd0);
        @(posedge clk);
        #1;
        bus.ld_en    = 1'b0;
        mem_m[100]   = 8'h5A;
        do_req(64'd96, 1, 1'b0);

        // Reset in the third READ cycle aborts the fetch; storage survives.
        bus.req_valid = 1'b1;
        bus.req_pc    = 64'd0;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_valid", 80'(bus.rsp_valid), 80'd0);
        check("abort_busy", 80'(busy), 80'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_req(64'd0, 2, 1'b0);

        // Load attempt during READ must be dropped.
        do_req(64'd0, 0, 1'b1);
        do_req(64'd0, 0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 2)) load_byte(AW'($urandom_range(0, DEPTH - 1)), 8'($urandom));
            sel = $urandom_range(0, 3);
            case (sel)
                0:       pc = 64'($urandom_range(2030, 2047));
                1:       pc = {32'($urandom), 32'($urandom)} | 64'h8000_0000_0000_0000;
                default: pc = 64'($urandom_range(0, DEPTH - 10));
            endcase
            do_req(pc, $urandom_range(0, 3), 1'b0);
        end

        repeat (2) @(posedge clk);
        #1;
        check("queue_drained", 80'(exp_q.size()), 80'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
